uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo_if.sv | 52 +++++
 rtl/uart_sync_fifo.sv | 81 ++++++++
 rtl/uart_tx_fifo.sv | 138 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared constants and launch-sequencer state type for uart_tx_fifo.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int BYTE_W          = 8;
    localparam int TX_RETRY_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
//  Module   : uart_tx_fifo_if
//  Brief    : Producer-side push port plus transmitter launch handshake.
//             UART_TX_FIFO_STATS_EN adds the overflow statistics signals.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                         wr_en;
    logic [uart_pkg::BYTE_W-1:0]  wr_data;
    logic                         full;
    logic                         empty;
    logic [LW-1:0]                level;
    logic                         start_write;
    logic [uart_pkg::BYTE_W-1:0]  write_data;
    logic                         write_avl;
    logic                         busy;
`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0]                  ovf_count;
    logic                         ovf_sticky;

    modport master (
        output wr_en, wr_data, write_avl,
        input  full, empty, level, start_write, write_data, busy,
        input  ovf_count, ovf_sticky
    );

    modport slave (
        input  wr_en, wr_data, write_avl,
        output full, empty, level, start_write, write_data, busy,
        output ovf_count, ovf_sticky
    );
`else
    modport master (
        output wr_en, wr_data, write_avl,
        input  full, empty, level, start_write, write_data, busy
    );

    modport slave (
        input  wr_en, wr_data, write_avl,
        output full, empty, level, start_write, write_data, busy
    );
`endif

endinterface

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ============================================================================
//  Module   : uart_sync_fifo
//  Brief    : Power-of-two synchronous FIFO with occupancy level and drop strobe.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = BYTE_W
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    input  wire logic                         push_req,
    input  wire logic [WIDTH-1:0]             push_data,
    input  wire logic                         pop,
    output logic      [WIDTH-1:0]             head,
    output logic                              full,
    output logic                              empty,
    output logic      [$clog2(DEPTH):0]       level,
    output logic                              drop
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              LW       = AW + 1;
    localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);
    // Full is judged on the pre-edge level, so a push while full is lost even
    // when a pop frees a slot on the same edge.
    assign w_push  = push_req && !w_full;
    assign w_pop   = pop && !w_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = w_full;
    assign empty = w_empty;
    assign level = r_level;
    assign drop  = push_req && w_full;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : Byte FIFO that drains one byte per frame into the UART transmitter.
//             Define UART_TX_FIFO_STATS_EN for overflow count/sticky outputs.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  wire logic     clk,
    input  wire logic     reset,
    uart_tx_fifo_if.slave bus
);

    localparam int              LW         = $clog2(DEPTH) + 1;
    localparam int              RW         = $clog2(TX_RETRY_CYCLES + 1);
    localparam logic [RW-1:0]   RETRY_LAST = RW'(TX_RETRY_CYCLES - 1);

    tx_state_t          r_state;
    tx_state_t          w_next_state;
    logic [RW-1:0]      r_retry;
    logic [RW-1:0]      w_next_retry;
    logic               r_start_write;
    logic [BYTE_W-1:0]  r_write_data;

    logic               w_pop;
    logic [BYTE_W-1:0]  w_head;
    logic               w_full;
    logic               w_empty;
    logic [LW-1:0]      w_level;
    logic               w_drop;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_req  (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (w_level),
        .drop      (w_drop)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_retry = r_retry;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && bus.write_avl) begin
                    w_pop        = 1'b1;
                    w_next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                w_next_state = WAIT_BUSY;
                w_next_retry = '0;
            end
            WAIT_BUSY: begin
                // A transmitter that stays idle never saw the strobe: re-pulse
                // the same byte rather than popping a new one.
                if (!bus.write_avl) begin
                    w_next_state = WAIT_DONE;
                end else if (r_retry == RETRY_LAST) begin
                    w_next_state = LAUNCH;
                end else begin
                    w_next_retry = r_retry + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.write_avl) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_retry       <= '0;
            r_start_write <= 1'b0;
            r_write_data  <= '0;
        end else begin
            r_state       <= w_next_state;
            r_retry       <= w_next_retry;
            r_start_write <= (w_next_state == LAUNCH);
            if (w_pop) begin
                r_write_data <= w_head;
            end
        end
    end

`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0] r_ovf_count;
    logic        r_ovf_sticky;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_count  <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (w_drop) begin
            r_ovf_sticky <= 1'b1;
            if (r_ovf_count != 16'hFFFF) begin
                r_ovf_count <= r_ovf_count + 16'd1;
            end
        end
    end

    assign bus.ovf_count  = r_ovf_count;
    assign bus.ovf_sticky = r_ovf_sticky;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.level       = w_level;
    assign bus.start_write = r_start_write;
    assign bus.write_data  = r_write_data;
    assign bus.busy        = (r_state != IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Brief    : Self-checking bench for uart_tx_fifo against a queue-based model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: byte queue plus the launch phase of the current byte.
    localparam int PH_IDLE = 0, PH_STROBE = 1, PH_ACK = 2, PH_FRAME = 3;
    logic [7:0]  m_q [$];
    int          m_phase;
    int          m_highs;
    logic [7:0]  m_wd;
    int          m_ovf;
    bit          m_sticky;

    int          tx_cnt;
    logic [7:0]  launched [$];

    typedef struct {
        logic       we;
        logic [7:0] d;
        logic       avl;
        int         lvl;
        logic       sw;
        logic [7:0] wd;
        logic       busy;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase  = PH_IDLE;
        m_highs  = 0;
        m_wd     = 8'h00;
        m_ovf    = 0;
        m_sticky = 0;
        tx_cnt   = 0;
    endtask

    task automatic model_edge(input logic we, input logic [7:0] d, input logic avl);
        bit accept;
        accept = we && (m_q.size() < DEPTH);
        if (we && !accept) begin
            if (m_ovf < 65535) m_ovf++;
            m_sticky = 1;
        end
        case (m_phase)
            PH_IDLE:   if (m_q.size() > 0 && avl) begin m_wd = m_q.pop_front(); m_phase = PH_STROBE; end
            PH_STROBE: begin m_phase = PH_ACK; m_highs = 0; end
            PH_ACK: begin
                if (!avl) m_phase = PH_FRAME;
                else begin
                    m_highs++;
                    if (m_highs == TX_RETRY_CYCLES) m_phase = PH_STROBE;
                end
            end
            default:   if (avl) m_phase = PH_IDLE;
        endcase
        if (accept) m_q.push_back(d);
    endtask

    task automatic check_outputs();
        chk("level", 32'(bus.level), 32'(m_q.size()));
        chk("empty", 32'(bus.empty), 32'(m_q.size() == 0));
        chk("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
        chk("busy", 32'(bus.busy), 32'(m_phase != PH_IDLE || m_q.size() != 0));
        chk("start_write", 32'(bus.start_write), 32'(m_phase == PH_STROBE));
        chk("write_data", 32'(bus.write_data), 32'(m_wd));
`ifdef UART_TX_FIFO_STATS_EN
        chk("ovf_count", 32'(bus.ovf_count), 32'(m_ovf));
        chk("ovf_sticky", 32'(bus.ovf_sticky), 32'(m_sticky));
`endif
    endtask

    task automatic step(input logic we, input logic [7:0] d, input logic avl);
        bus.wr_en     = we;
        bus.wr_data   = d;
        bus.write_avl = avl;
        @(posedge clk);
        model_edge(we, d, avl);
        #1;
        check_outputs();
    endtask

    // Transmitter that accepts a strobe while idle and then stays busy for a frame.
    task automatic tx_cycle(input logic we, input logic [7:0] d, input int frame_max);
        logic       avl;
        logic       sw_pre;
        logic [7:0] wd_pre;
        avl    = (tx_cnt == 0);
        sw_pre = bus.start_write;
        wd_pre = bus.write_data;
        step(we, d, avl);
        if (sw_pre && avl) begin
            tx_cnt = $urandom_range(frame_max, 1);
            launched.push_back(wd_pre);
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (bus.busy || tx_cnt != 0); i++) begin
            tx_cycle(1'b0, 8'h00, 3);
        end
        chk("drain_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        tbl[0] = '{1'b1, 8'h55, 1'b1, 1, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h55, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h55, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h55, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h55, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h55, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h55, 1'b0};

        bus.wr_en     = 1'b0;
        bus.wr_data   = 8'h00;
        bus.write_avl = 1'b1;
        do_reset();
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // Single byte: launch two cycles after the push, busy until avl returns.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].we, tbl[i].d, tbl[i].avl);
            chk($sformatf("tbl%0d_level", i), 32'(bus.level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_sw", i), 32'(bus.start_write), 32'(tbl[i].sw));
            chk($sformatf("tbl%0d_wd", i), 32'(bus.write_data), 32'(tbl[i].wd));
            chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
        end

        // Burst to full with the transmitter busy, then one dropped push.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
        chk("burst_full", 32'(bus.full), 32'd1);
        step(1'b1, 8'hAA, 1'b0);
        chk("drop_level", 32'(bus.level), 32'(DEPTH));
`ifdef UART_TX_FIFO_STATS_EN
        chk("drop_ovf_count", 32'(bus.ovf_count), 32'd1);
        chk("drop_ovf_sticky", 32'(bus.ovf_sticky), 32'd1);
`endif
        launched.delete();
        drain(600);
        chk("burst_count", 32'(launched.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < launched.size(); i++)
            chk($sformatf("burst_byte%0d", i), 32'(launched[i]), 32'(i));
        chk("burst_empty", 32'(bus.empty), 32'd1);

        // Transmitter ignoring the strobe: re-pulse every 3 cycles, no pop.
        step(1'b1, 8'h3C, 1'b1);
        cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) step(1'b1, 8'h3D, 1'b1);
            else        step(1'b0, 8'h00, 1'b1);
            if (bus.start_write) cnt++;
        end
        chk("retry_pulses", 32'(cnt), 32'd4);
        chk("retry_level", 32'(bus.level), 32'd1);
        chk("retry_data", 32'(bus.write_data), 32'h3C);
        launched.delete();
        drain(100);
        chk("order_count", 32'(launched.size()), 32'd2);
        if (launched.size() == 2) begin
            chk("order_first", 32'(launched[0]), 32'h3C);
            chk("order_second", 32'(launched[1]), 32'h3D);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++)
            tx_cycle($urandom_range(99, 0) < 45, 8'($urandom), 4);
        drain(600);

        // Async reset while in WAIT_DONE with 5 bytes queued.
        do_reset();
        step(1'b1, 8'hA0, 1'b1);
        step(1'b1, 8'hA1, 1'b1);
        step(1'b1, 8'hA2, 1'b1);
        step(1'b1, 8'hA3, 1'b0);
        step(1'b1, 8'hA4, 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        chk("pre_rst_level", 32'(bus.level), 32'd5);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("async_level", 32'(bus.level), 32'd0);
        chk("async_wd", 32'(bus.write_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (bus.start_write) cnt++;
        end
        chk("post_rst_pulses", 32'(cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
